// File: rtl/phase_sequencer_if.sv
// Control and status bundle between the phase sequencer and the register sequencer / datapath.
// The master side drives run control and memory status; the slave side is the sequencer.
interface phase_sequencer_if;
    logic        RUN;
    logic        STEP;
    logic        MEM_WAIT;
    logic        LONG_OP;
    logic        FETCH;
    logic        DECODE;
    logic        EXECUTE;
    logic        COMMIT;
    logic        HALTED;
    logic [15:0] INSTR_COUNT;
    logic [7:0]  WAIT_COUNT;

    modport master (
        output RUN, STEP, MEM_WAIT, LONG_OP,
        input  FETCH, DECODE, EXECUTE, COMMIT, HALTED, INSTR_COUNT, WAIT_COUNT
    );

    modport slave (
        input  RUN, STEP, MEM_WAIT, LONG_OP,
        output FETCH, DECODE, EXECUTE, COMMIT, HALTED, INSTR_COUNT, WAIT_COUNT
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: HALT -> FETCH -> DECODE -> EXECUTE -> COMMIT with run/step
// control, memory wait stretching, and committed-instruction / wait-cycle counters.
module phase_sequencer (
    input logic              CLK,
    input logic              RESET,
    phase_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StHalt    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StCommit  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        step_pending_q, step_pending_d;
    logic        fetch_q, decode_q, execute_q, commit_q, halted_q;
    logic [15:0] instr_count_q;
    logic [7:0]  wait_count_q;
    logic        wait_cycle;

    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        case (state_q)
            StHalt: begin
                if (bus.RUN || bus.STEP) begin
                    state_d        = StFetch;
                    step_pending_d = bus.STEP && !bus.RUN;
                end
            end
            StFetch: begin
                if (!bus.MEM_WAIT) state_d = StDecode;
            end
            StDecode: state_d = StExecute;
            StExecute: begin
                if (!(bus.LONG_OP && bus.MEM_WAIT)) state_d = StCommit;
            end
            StCommit: begin
                // A single-step instruction always returns to HALT, even if RUN rose meanwhile.
                state_d        = (bus.RUN && !step_pending_q) ? StFetch : StHalt;
                step_pending_d = 1'b0;
            end
            default: begin
                state_d        = StHalt;
                step_pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wait_cycle = bus.MEM_WAIT &&
                     ((state_q == StFetch) || ((state_q == StExecute) && bus.LONG_OP));
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= StHalt;
            step_pending_q <= 1'b0;
            fetch_q        <= 1'b0;
            decode_q       <= 1'b0;
            execute_q      <= 1'b0;
            commit_q       <= 1'b0;
            halted_q       <= 1'b1;
            instr_count_q  <= 16'h0000;
            wait_count_q   <= 8'h00;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            fetch_q        <= (state_d == StFetch);
            decode_q       <= (state_d == StDecode);
            execute_q      <= (state_d == StExecute);
            commit_q       <= (state_d == StCommit);
            halted_q       <= (state_d == StHalt);
            if (state_q == StCommit) begin
                instr_count_q <= instr_count_q + 16'd1;
            end
            if (wait_cycle && (wait_count_q != 8'hFF)) begin
                wait_count_q <= wait_count_q + 8'd1;
            end
        end
    end

    assign bus.FETCH       = fetch_q;
    assign bus.DECODE      = decode_q;
    assign bus.EXECUTE     = execute_q;
    assign bus.COMMIT      = commit_q;
    assign bus.HALTED      = halted_q;
    assign bus.INSTR_COUNT = instr_count_q;
    assign bus.WAIT_COUNT  = wait_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomised bench for phase_sequencer: an instruction-level model queues expected latency and
// counter values per instruction; a monitor checks them whenever COMMIT is presented.
module tb_phase_sequencer;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    phase_sequencer_if bus ();

    phase_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          lat;
        logic [15:0] cnt;
        logic [7:0]  wcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_count;
    int          m_wait;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor
    int   lat = 0;
    bit   prev_f = 0;
    bit   chk_next = 0;
    exp_t cur;

    always @(negedge CLK) begin
        if (!RESET) begin
            check("one_phase_or_halted",
                  $countones({bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT, bus.HALTED}), 1);
            if (chk_next) begin
                check("instr_count", int'(bus.INSTR_COUNT), int'(cur.cnt));
                check("wait_count", int'(bus.WAIT_COUNT), int'(cur.wcnt));
                chk_next = 0;
            end
            if (bus.FETCH && !prev_f) lat = 1;
            else if (!bus.HALTED) lat++;
            prev_f = bus.FETCH;
            if (bus.COMMIT) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("latency", lat, cur.lat);
                    chk_next = 1;
                end
            end
        end
    end

    always @(posedge RESET) begin
        exp_q.delete();
        chk_next = 0;
        prev_f   = 0;
        lat      = 0;
    end

    // mode: 0 = RUN, 1 = STEP only, 2 = RUN and STEP together (only used when halted).
    task automatic do_instr(input int nf, input bit lo, input int ne, input int mode,
                            input bit run_after, input bit drop_d, input bit rst_e);
        int   fw = nf;
        int   ew = ne;
        int   guard = 0;
        int   w;
        bit   pend = 0;
        bit   done = 0;
        exp_t e;
        w = nf + (lo ? ne : 0);
        if (bus.HALTED) begin
            bus.RUN  = (mode != 1);
            bus.STEP = (mode != 0);
            pend     = (mode == 1);
            @(negedge CLK);
        end
        m_count = m_count + 16'd1;
        m_wait  = (m_wait + w > 255) ? 255 : m_wait + w;
        e.lat   = 4 + w;
        e.cnt   = m_count;
        e.wcnt  = m_wait[7:0];
        exp_q.push_back(e);
        while (!done) begin
            if (guard++ > 2000) begin
                check("instr_timeout", guard, 2000);
                return;
            end
            if (bus.FETCH) begin
                bus.MEM_WAIT = (fw > 0);
                if (fw > 0) fw--;
                bus.LONG_OP = 1'($urandom);
                bus.STEP    = 1'($urandom);
                bus.RUN     = drop_d ? bus.RUN : 1'($urandom);
            end else if (bus.DECODE) begin
                bus.MEM_WAIT = 1'($urandom);
                bus.LONG_OP  = 1'($urandom);
                bus.STEP     = 1'($urandom);
                bus.RUN      = drop_d ? 1'b0 : 1'($urandom);
            end else if (bus.EXECUTE) begin
                if (rst_e) begin
                    RESET = 1'b1;
                    #1;
                    check("rst_strobes",
                          $countones({bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT}), 0);
                    check("rst_halted", bus.HALTED, 1);
                    check("rst_instr_count", int'(bus.INSTR_COUNT), 0);
                    check("rst_wait_count", int'(bus.WAIT_COUNT), 0);
                    bus.RUN = 0; bus.STEP = 0; bus.MEM_WAIT = 0; bus.LONG_OP = 0;
                    m_count = 16'h0000;
                    m_wait  = 0;
                    repeat (2) @(negedge CLK);
                    RESET = 1'b0;
                    repeat (4) begin
                        @(negedge CLK);
                        check("rst_stay_halted", bus.HALTED, 1);
                    end
                    return;
                end
                bus.LONG_OP  = lo;
                bus.MEM_WAIT = lo ? (ew > 0) : 1'($urandom);
                if (lo && ew > 0) ew--;
                bus.STEP = 1'b1;  // stray step outside HALT must be ignored
                if (!drop_d) bus.RUN = 1'($urandom);
            end else if (bus.COMMIT) begin
                bus.MEM_WAIT = 1'($urandom);
                bus.LONG_OP  = 1'($urandom);
                bus.STEP     = 1'($urandom);
                bus.RUN      = run_after;
                done = 1;
            end else begin
                check("halted_mid_instr", 1, 0);
                return;
            end
            if (!done) @(negedge CLK);
        end
        @(negedge CLK);
        check("halt_after_commit", bus.HALTED, int'(pend || !run_after));
        bus.STEP = 1'b0;
    endtask

    initial begin
        bus.RUN = 0; bus.STEP = 0; bus.MEM_WAIT = 0; bus.LONG_OP = 0;
        m_count = 16'h0000;
        m_wait  = 0;
        RESET   = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_halted", bus.HALTED, 1);
        check("reset_strobes", $countones({bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT}), 0);
        check("reset_instr_count", int'(bus.INSTR_COUNT), 0);
        check("reset_wait_count", int'(bus.WAIT_COUNT), 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_after_reset", bus.HALTED, 1);

        repeat (3) do_instr(0, 0, 0, 0, 1, 0, 0);
        do_instr(3, 1, 2, 0, 0, 0, 0);
        do_instr(1, 0, 2, 1, 0, 0, 0);
        do_instr(1, 1, 1, 1, 1, 0, 0);
        do_instr(0, 0, 0, 2, 1, 0, 0);
        do_instr(0, 1, 0, 0, 0, 1, 0);
        repeat (5) begin
            @(negedge CLK);
            check("no_fetch_after_drop", bus.HALTED, 1);
        end

        for (int i = 0; i < 150; i++) begin
            int nf, ne, mode;
            bit lo, ra, dd;
            nf   = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 2);
            ne   = $urandom_range(0, 4);
            lo   = 1'($urandom);
            mode = $urandom_range(0, 2);
            dd   = ($urandom_range(0, 7) == 0);
            ra   = dd ? 1'b0 : 1'($urandom);
            do_instr(nf, lo, ne, mode, ra, dd, 0);
        end

        do_instr(1, 1, 1, 0, 1, 0, 1);

        // Preload the commit counter so wrap-around is reached without 65535 instructions.
        dut.instr_count_q <= 16'hFFFE;
        m_count = 16'hFFFE;
        @(negedge CLK);
        do_instr(150, 1, 150, 0, 1, 0, 0);
        do_instr(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port RUN  input  1  level; 1 = free-run instructions, 0 = halt at next instruction boundary.
REQ-004 SHALL have port STEP  input  1  one-cycle pulse; requests execution of exactly one instruction while halted.
REQ-005 SHALL have port MEM_WAIT  input  1  memory not ready; stretches FETCH, and EXECUTE when LONG_OP=1.
REQ-006 SHALL have port LONG_OP  input  1  decoded instruction performs a data-memory access; sampled only in EXECUTE.
REQ-007 SHALL have ports FETCH, DECODE, EXECUTE, COMMIT  output  1 each  registered phase strobes driving the register sequencer and datapath.
REQ-008 SHALL have port HALTED  output  1  registered; 1 while the sequencer is in HALT.
REQ-009 SHALL have port INSTR_COUNT  output  16  registered count of committed instructions.
REQ-010 SHALL have port WAIT_COUNT  output  8  registered count of memory wait cycles, saturating.

Function
REQ-011 SHALL implement states HALT, F, D, E, C; FETCH/DECODE/EXECUTE/COMMIT SHALL be 1 exactly in F/D/E/C respectively; at most one SHALL be 1 in any cycle; all SHALL be 0 in HALT.
REQ-012 HALT -> F when RUN=1 or STEP=1 at a rising edge; else stay in HALT.
REQ-013 F -> D when MEM_WAIT=0; F holds while MEM_WAIT=1, with no upper bound.
REQ-014 D -> E unconditionally; each D SHALL last exactly one cycle.
REQ-015 E -> C when LONG_OP=0, or when LONG_OP=1 and MEM_WAIT=0; E holds while LONG_OP=1 and MEM_WAIT=1.
REQ-016 C SHALL last exactly one cycle; C -> HALT if step_pending=1, else C -> F if RUN=1, else C -> HALT.
REQ-017 step_pending SHALL be an internal flag set on HALT -> F when STEP=1 and RUN=0, and cleared on leaving C.
REQ-018 STEP pulses arriving outside HALT SHALL be ignored, with no queueing.
REQ-019 RUN falling mid-instruction SHALL NOT abort the instruction; F/D/E/C SHALL complete and the sequencer SHALL halt after C.
REQ-020 STEP=1 and RUN=1 together in HALT SHALL behave as RUN=1, i.e. free-run with step_pending=0.
REQ-021 Minimum instruction latency SHALL be 4 cycles (F,D,E,C); each counted wait cycle adds 1.
REQ-022 INSTR_COUNT SHALL increment by 1 on every exit from C and wrap from 0xFFFF to 0x0000.
REQ-023 WAIT_COUNT SHALL increment by 1 for every cycle held in F by MEM_WAIT, or held in E by LONG_OP&MEM_WAIT, and saturate at 0xFF.
REQ-024 MEM_WAIT SHALL be ignored in HALT, D and C, and in E when LONG_OP=0.
REQ-025 HALTED SHALL equal 1 in the same cycle the state is HALT, since it is registered alongside the state.
REQ-026 The state encoding SHALL have no reachable illegal states; any illegal encoding SHALL recover to HALT on the next clock.

Reset
REQ-027 RESET=1 SHALL asynchronously force: state=HALT, FETCH=DECODE=EXECUTE=COMMIT=0, HALTED=1, step_pending=0, INSTR_COUNT=0x0000, WAIT_COUNT=0x00.
REQ-028 RESET asserted mid-instruction, in any state, SHALL abandon the instruction with no COMMIT pulse.
REQ-029 After RESET deasserts, the first transition SHALL follow REQ-012.

Verification
REQ-030 Reset, RUN=1, MEM_WAIT=0, LONG_OP=0 for 12 cycles -> phases F,D,E,C repeat with period 4; INSTR_COUNT=3 after the third C; HALTED=0 from the first F.
REQ-031 RUN=1; MEM_WAIT=1 for 3 cycles in F, then LONG_OP=1 with MEM_WAIT=1 for 2 cycles in E -> instruction takes 9 cycles; WAIT_COUNT=5; exactly one COMMIT.
REQ-032 Halted, RUN=0, single STEP pulse -> exactly one F,D,E,C then HALT; INSTR_COUNT +1; a second STEP during E is ignored.
REQ-033 RUN=1, then RUN->0 during D -> current instruction completes through C, then HALTED=1; no further FETCH.
REQ-034 INSTR_COUNT preloaded by running 65535 instructions, one more C -> INSTR_COUNT=0x0000; WAIT_COUNT held at 0xFF under 300 wait cycles.
REQ-035 RESET pulsed during E -> all strobes 0 immediately, HALTED=1, counters 0, no COMMIT observed.
